// File: rtl/timing.sv
// G15 drum timing generator: 8-clk bit times, 29-digit words, 108-word revolutions.
// Produces the bit clock CL, the gated shift clock CR and the digit-time decodes.
module timing (
   input  logic clk,
   input  logic rst,
   input  logic CJ,
   input  logic CN,
   input  logic RC,
   output logic CL,
   output logic CR,
   output logic T0,
   output logic T1,
   output logic T2,
   output logic T13,
   output logic T21,
   output logic T28,
   output logic T29
);

   localparam logic [2:0] P_LAST = 3'd7;
   localparam logic [4:0] D_LAST = 5'd28;
   localparam logic [6:0] W_LAST = 7'd107;

   logic [2:0] p_q, p_d;
   logic [4:0] d_q, d_d;
   logic [6:0] w_q, w_d;
   logic       bit_end_s;
   logic       digit_wrap_s;
   logic       se_s;

   // Next-state logic for the prescaler, digit and word counters
   always_comb begin
      bit_end_s    = (p_q == P_LAST);
      digit_wrap_s = bit_end_s && (d_q >= D_LAST);
      p_d          = p_q + 3'd1;
      d_d          = d_q;
      w_d          = w_q;
      if (bit_end_s) begin
         // Out-of-range counts fold back to 0 rather than running away
         if (d_q >= D_LAST) begin
            d_d = 5'd0;
         end else begin
            d_d = d_q + 5'd1;
         end
      end else begin
         d_d = d_q;
      end
      if (digit_wrap_s) begin
         if (w_q >= W_LAST) begin
            w_d = 7'd0;
         end else begin
            w_d = w_q + 7'd1;
         end
      end else begin
         w_d = w_q;
      end
   end

   // Counter state registers, cleared asynchronously while rst is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q <= 3'd0;
         d_q <= 5'd0;
         w_q <= 7'd0;
      end else begin
         p_q <= p_d;
         d_q <= d_d;
         w_q <= w_d;
      end
   end

   // Output decodes from registered counter state; CR gates CL with the shift enable
   always_comb begin
      se_s = CN | (RC & CJ);
      CL   = (p_q == P_LAST);
      CR   = CL & se_s;
      T0   = (d_q == 5'd0);
      T1   = (d_q == 5'd1);
      T2   = (d_q == 5'd2);
      T13  = (d_q == 5'd13);
      T21  = (d_q == 5'd21);
      T28  = (d_q == D_LAST);
      T29  = (d_q == D_LAST) && (w_q == W_LAST);
   end

endmodule

// File: tb/tb_timing.sv
// Randomized self-checking bench for timing against an arithmetic model of
// elapsed clocks since reset release.
module tb_timing;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic CJ = 1'b0;
   logic CN = 1'b0;
   logic RC = 1'b0;
   logic CL, CR, T0, T1, T2, T13, T21, T28, T29;
   logic [8:0] dut_v;
   logic [8:0] exp_v;

   int checks = 0;
   int failures = 0;
   int n = 0;

   timing dut (
      .clk(clk), .rst(rst), .CJ(CJ), .CN(CN), .RC(RC),
      .CL(CL), .CR(CR), .T0(T0), .T1(T1), .T2(T2),
      .T13(T13), .T21(T21), .T28(T28), .T29(T29)
   );

   always #5 clk = ~clk;

   assign dut_v = {CL, CR, T0, T1, T2, T13, T21, T28, T29};

   // Reference: outputs as a function of clocks elapsed since release
   function automatic logic [8:0] ref_out(input int cyc, input logic in_reset,
                                          input logic cj, input logic cn, input logic rc);
      int p, d, w;
      logic cl, se;
      if (in_reset) return 9'b001000000;
      p  = cyc % 8;
      d  = (cyc / 8) % 29;
      w  = (cyc / 232) % 108;
      cl = (p == 7);
      se = cn | (rc & cj);
      return {cl, cl & se, d == 0, d == 1, d == 2, d == 13, d == 21, d == 28,
              (d == 28) && (w == 107)};
   endfunction

   task automatic advance();
      @(posedge clk);
      #1;
      n = n + 1;
   endtask

   task automatic drive_rand();
      CJ = 1'($urandom_range(0, 1));
      CN = 1'($urandom_range(0, 1));
      RC = 1'($urandom_range(0, 1));
   endtask

   task automatic restart();
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      n = 0;
   endtask

   task automatic test_reset();
      CJ = 1'b1; CN = 1'b1; RC = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #7;
         exp_v = ref_out(0, 1'b1, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL reset_hold t=%0t got=%b exp=%b", $time, dut_v, exp_v);
         end
      end
      @(posedge clk);
      #1 rst = 1'b1;
      n = 0;
      CJ = 1'b0; CN = 1'b0; RC = 1'b0;
      #3;
      exp_v = ref_out(n, 1'b0, CJ, CN, RC);
      checks++;
      if (dut_v !== exp_v) begin
         failures++;
         $display("FAIL reset_release got=%b exp=%b", dut_v, exp_v);
      end
   endtask

   task automatic test_idle();
      CJ = 1'b0; CN = 1'b0; RC = 1'b0;
      for (int i = 0; i < 300; i++) begin
         advance();
         #3;
         exp_v = ref_out(n, 1'b0, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL idle cyc=%0d got=%b exp=%b", n, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_shift_enable();
      for (int i = 0; i < 600; i++) begin
         advance();
         drive_rand();
         #2;
         exp_v = ref_out(n, 1'b0, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL shift_en_a cyc=%0d in=%b%b%b got=%b exp=%b",
                     n, CJ, CN, RC, dut_v, exp_v);
         end
         drive_rand();
         #2;
         exp_v = ref_out(n, 1'b0, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL shift_en_b cyc=%0d in=%b%b%b got=%b exp=%b",
                     n, CJ, CN, RC, dut_v, exp_v);
         end
      end
   endtask

   task automatic test_revolution();
      int t29_cnt;
      int t29_first;
      t29_cnt   = 0;
      t29_first = -1;
      restart();
      while (n < 25060) begin
         advance();
         if ((n % 5) == 0) drive_rand();
         #3;
         exp_v = ref_out(n, 1'b0, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL revolution cyc=%0d got=%b exp=%b", n, dut_v, exp_v);
         end
         if (T29 === 1'b1) begin
            if (t29_first < 0) t29_first = n;
            t29_cnt++;
         end
      end
      checks++;
      if (t29_cnt != 8) begin
         failures++;
         $display("FAIL t29_width got=%0d exp=8", t29_cnt);
      end
      checks++;
      if (t29_first != 25048) begin
         failures++;
         $display("FAIL t29_start got=%0d exp=25048", t29_first);
      end
   endtask

   task automatic test_mid_reset();
      restart();
      CJ = 1'b0; CN = 1'b1; RC = 1'b0;
      while (n < 108) advance();
      #1;
      exp_v = ref_out(n, 1'b0, CJ, CN, RC);
      checks++;
      if ((dut_v !== exp_v) || (T13 !== 1'b1)) begin
         failures++;
         $display("FAIL pre_abort cyc=%0d got=%b exp=%b", n, dut_v, exp_v);
      end
      #1 rst = 1'b0;
      #1;
      exp_v = ref_out(0, 1'b1, CJ, CN, RC);
      checks++;
      if (dut_v !== exp_v) begin
         failures++;
         $display("FAIL abort_async got=%b exp=%b", dut_v, exp_v);
      end
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      n = 0;
      for (int i = 0; i < 250; i++) begin
         #3;
         exp_v = ref_out(n, 1'b0, CJ, CN, RC);
         checks++;
         if (dut_v !== exp_v) begin
            failures++;
            $display("FAIL restart cyc=%0d got=%b exp=%b", n, dut_v, exp_v);
         end
         advance();
         drive_rand();
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_shift_enable();
      test_revolution();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
